// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the MEM-stage sequencer: state encoding and defaults.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } mem_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 8;
    localparam int unsigned DEFAULT_CW      = 8;

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: memory strobes, upstream freeze and MEM_WB bubble while a
// variable-latency access is pending, with a watchdog that aborts hung accesses.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CW      = DEFAULT_CW
) (
    input  logic reloj,
    input  logic reset,
    input  logic mem_rd,
    input  logic mem_wr,
    input  logic mem_ready,
    output logic mem_en,
    output logic mem_we,
    output logic stall,
    output logic bubble_wb,
    output logic err
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          req;

    assign req = mem_rd | mem_wr;
    assign err = err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge reloj) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mem_en    = 1'b0;
        stall     = 1'b0;
        bubble_wb = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                mem_en = req;
                if (req && !mem_ready) begin
                    stall     = 1'b1;
                    bubble_wb = 1'b1;
                    cnt_d     = CNT_ONE;
                    state_d   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                mem_en = req;
                if (!req || mem_ready) begin
                    // Squashed or completed: ready wins over the timeout check.
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    stall     = 1'b1;
                    bubble_wb = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_ABORT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            ST_ABORT: begin
                // Faulting instruction leaves MEM as a bubble; pipeline resumes.
                bubble_wb = 1'b1;
                err_d     = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_we = mem_wr & mem_en;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a stall-counting reference model.
module tb_mem_stage_ctrl;

    localparam int TO = 8;

    logic reloj;
    logic reset;
    logic mem_rd, mem_wr, mem_ready;
    logic mem_en, mem_we, stall, bubble_wb, err;

    int n_total = 0;
    int n_pass  = 0;

    mem_stage_ctrl #(.TIMEOUT(TO), .CW(8)) dut (
        .reloj     (reloj),
        .reset     (reset),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_ready (mem_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .stall     (stall),
        .bubble_wb (bubble_wb),
        .err       (err)
    );

    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    // Expected vectors are packed as {mem_en, mem_we, stall, bubble_wb, err}.
    typedef struct {
        bit         rd;
        bit         wr;
        bit         rdy;
        logic [4:0] exp;
        string      name;
    } vec_t;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got en/we/stall/bub/err=%b expected %b at %0t", name, act, exp, $time);
    endtask

    // Called just after a rising edge: drive, settle, compare, advance one cycle.
    task automatic step(input bit r, input bit rd, input bit wr, input bit rdy,
                        input logic [4:0] exp, input string name);
        reset     = r;
        mem_rd    = rd;
        mem_wr    = wr;
        mem_ready = rdy;
        #2;
        check(name, {mem_en, mem_we, stall, bubble_wb, err}, exp);
        @(posedge reloj);
        #1;
    endtask

    // Reference model: counts stall cycles of the current access.
    int waited     = 0;
    bit abort_next = 0;
    bit err_m      = 0;

    function automatic logic [4:0] model_expect(input bit rd, input bit wr, input bit rdy);
        bit r;
        bit st;
        r = rd | wr;
        if (abort_next) return {4'b0001, err_m};
        st = r & ~rdy;
        return {r, wr & r, st, st, err_m};
    endfunction

    function automatic void model_update(input bit rst, input bit rd, input bit wr, input bit rdy);
        if (rst) begin
            waited = 0; abort_next = 0; err_m = 0;
        end else if (abort_next) begin
            abort_next = 0; err_m = 1; waited = 0;
        end else if ((rd | wr) && !rdy) begin
            waited++;
            if (waited == TO) begin
                abort_next = 1;
                waited     = 0;
            end
        end else begin
            waited = 0;
        end
    endfunction

    initial begin
        vec_t vecs[$];
        int   ready_pct;
        int   op;

        reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_ready = 1'b0;
        @(posedge reloj); #1;
        @(posedge reloj); #1;
        reset = 1'b0;
        #1;
        check("reset_state", {mem_en, mem_we, stall, bubble_wb, err}, 5'b00000);

        vecs.push_back('{0, 0, 1, 5'b00000, "idle_ready_ignored"});
        vecs.push_back('{1, 0, 1, 5'b10000, "zero_wait_load"});
        vecs.push_back('{0, 1, 1, 5'b11000, "zero_wait_store"});
        vecs.push_back('{0, 1, 0, 5'b11110, "store_wait1"});
        vecs.push_back('{0, 1, 0, 5'b11110, "store_wait2"});
        vecs.push_back('{0, 1, 0, 5'b11110, "store_wait3"});
        vecs.push_back('{0, 1, 1, 5'b11000, "store_done"});
        vecs.push_back('{1, 0, 0, 5'b10110, "b2b_load1_wait"});
        vecs.push_back('{1, 0, 1, 5'b10000, "b2b_load1_done"});
        vecs.push_back('{1, 0, 0, 5'b10110, "b2b_load2_wait"});
        vecs.push_back('{1, 0, 1, 5'b10000, "b2b_load2_done"});
        vecs.push_back('{0, 0, 0, 5'b00000, "idle_gap"});
        vecs.push_back('{1, 0, 0, 5'b10110, "squash_wait1"});
        vecs.push_back('{1, 0, 0, 5'b10110, "squash_wait2"});
        vecs.push_back('{0, 0, 0, 5'b00000, "squashed"});
        vecs.push_back('{0, 0, 1, 5'b00000, "idle_after_squash"});
        vecs.push_back('{1, 0, 1, 5'b10000, "fresh_after_squash"});

        foreach (vecs[i]) step(0, vecs[i].rd, vecs[i].wr, vecs[i].rdy, vecs[i].exp, vecs[i].name);

        // Watchdog: TO stall cycles, one abort cycle, then sticky err.
        for (int i = 0; i < TO; i++) step(0, 1, 0, 0, 5'b10110, "timeout_stall");
        step(0, 1, 0, 0, 5'b00010, "abort_cycle");
        step(0, 0, 0, 0, 5'b00001, "err_sticky");
        step(0, 0, 1, 1, 5'b11001, "store_after_abort");
        step(1, 0, 0, 0, 5'b00001, "err_during_reset");
        step(0, 0, 0, 0, 5'b00000, "err_cleared");

        // Ready on the last allowed stall cycle completes normally.
        for (int i = 0; i < TO - 1; i++) step(0, 1, 0, 0, 5'b10110, "ready_wins_stall");
        step(0, 1, 0, 1, 5'b10000, "ready_wins_done");
        step(0, 0, 0, 0, 5'b00000, "ready_wins_no_err");

        // Reset in the middle of a wait drops the access without an error.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 5'b10110, "pre_reset_stall");
        step(1, 1, 0, 0, 5'b10110, "reset_in_wait");
        step(0, 0, 0, 0, 5'b00000, "idle_after_reset");
        step(0, 0, 1, 1, 5'b11000, "fresh_after_reset");

        // Randomized traffic against the reference model.
        waited = 0; abort_next = 0; err_m = 0;
        ready_pct = 30;
        op = 0;
        for (int c = 0; c < 3000; c++) begin
            bit r, rd, wr, rdy;
            logic [4:0] e;
            if (c % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ready_pct = 4;
                    1:       ready_pct = 30;
                    default: ready_pct = 80;
                endcase
            end
            if ($urandom_range(0, 99) < 20) op = $urandom_range(0, 2);
            r   = ($urandom_range(0, 199) == 0);
            rd  = (op == 1);
            wr  = (op == 2);
            rdy = ($urandom_range(0, 99) < ready_pct);
            e   = model_expect(rd, wr, rdy);
            step(r, rd, wr, rdy, e, "random");
            model_update(r, rd, wr, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM stage of the five-stage pipeline. It drives the data-memory enable and write strobe and handles variable-latency memory. While a load or store waits on `mem_ready`, it freezes the upstream stages (PC, IF_ID, ID_EX, EX_MEM). It also forces a bubble into MEM_WB through that register's synchronous clear, so no writeback repeats. A watchdog aborts accesses that never complete and raises a sticky error.

## Interface
- `TIMEOUT`, 8: maximum stalled cycles per access before abort; legal range 2..255.
- `CW`, 8: width of the internal wait counter; must hold `TIMEOUT`.

Ports:
- `reloj`  in  1  pipeline clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed.
- `mem_rd`  in  1  MEM-stage instruction is a load (from EX_MEM control bits).
- `mem_wr`  in  1  MEM-stage instruction is a store; never high together with `mem_rd`.
- `mem_ready`  in  1  data memory completes the access this cycle; read data valid on DO this cycle.
- `mem_en`  out  1  data-memory enable.
- `mem_we`  out  1  data-memory write enable.
- `stall`  out  1  hold PC, IF_ID, ID_EX, EX_MEM.
- `bubble_wb`  out  1  drives `resetMEM` of MEM_WB: load zeros into it at the next edge.
- `err`  out  1  sticky timeout flag.

## Operation
Definitions:
- `req = mem_rd | mem_wr`.
- FSM states, binary encoded: IDLE, WAIT, ABORT.
- Wait counter `cnt`, CW bits.

IDLE:
- `req & mem_ready`: zero-wait access. `stall=0`, `bubble_wb=0`; stay IDLE.
- `req & ~mem_ready`: `stall=1`, `bubble_wb=1`; `cnt<=1`; go to WAIT.
- `~req`: all strobes 0.

WAIT (`cnt` = stalled cycles already spent):
- `~req` (instruction squashed externally): `mem_en=0`, `stall=0`, `bubble_wb=0`; go to IDLE; no error.
- `mem_ready`: `stall=0`, `bubble_wb=0`. At the edge EX_MEM advances and MEM_WB captures DO. Go to IDLE.
- `~mem_ready` and `cnt==TIMEOUT-1`: this is stall cycle `TIMEOUT`; go to ABORT.
- `~mem_ready` otherwise: `stall=1`, `bubble_wb=1`; `cnt<=cnt+1`.

ABORT (one cycle):
- `mem_en=0`, `stall=0`, `bubble_wb=1`. The faulting instruction leaves MEM without writeback.
- `err<=1`; go to IDLE.

Strobes:
- `mem_en = req` in IDLE and WAIT; 0 in ABORT.
- `mem_we = mem_wr & mem_en`.

Flags:
- `err` is cleared only by `reset`.
- A new request in the cycle after completion or abort is a new instruction and starts a fresh access.

## Timing
- Reset values: state IDLE, `cnt=0`, `err=0`. Outputs are 0 in the cycle after reset, unless `req` is high then, since the strobes are combinational.
- `reset` mid-access: the next cycle is IDLE and the pending access is dropped without an error. The memory must tolerate `mem_en` falling.
- `mem_en`, `mem_we`, `stall` and `bubble_wb` are combinational from state, `req` and `mem_ready`: zero-cycle response. `err` is registered.
- Access latency: an access completing with `mem_ready` in cycle N after the request first appears costs exactly N stall cycles (N=0 for zero-wait).
- Maximum: `TIMEOUT` stall cycles plus one ABORT cycle.
- `mem_ready` outside an active request is ignored.
- `mem_ready` in the same cycle as the `cnt==TIMEOUT-1` condition completes normally: ready wins over timeout.
- `cnt` is never compared beyond `TIMEOUT-1`, so no wrap.

## Structure
- The shared pipeline package holds the state encoding localparams (ST_IDLE=2'd0, ST_WAIT=2'd1, ST_ABORT=2'd2) and the default `TIMEOUT`.
- Single module. Counter and FSM are inline; no sub-module is warranted.
- The top level wires `bubble_wb` to MEM_WB `resetMEM` (ORed with the global reset) and `stall` to the upstream register enables.

## Test plan
- Zero-wait load: `mem_rd=1`, `mem_ready=1` same cycle -> `mem_en=1`, `stall=0`, `bubble_wb=0`; state stays IDLE.
- 3-wait store: `mem_wr=1`, `mem_ready` high on the 4th cycle -> `stall=bubble_wb=1` for exactly 3 cycles, `mem_we=1` all 4 cycles, then IDLE.
- Timeout, `TIMEOUT=8`, `mem_ready` never high -> `stall=1` for 8 cycles, then one cycle `bubble_wb=1`/`stall=0`/`mem_en=0`, and `err=1` from the following cycle onward.
- `mem_ready` on stall cycle 8 with `TIMEOUT=8` -> normal completion, `err` stays 0.
- Back-to-back loads, each with 1 wait cycle -> 2 separate stall cycles separated by a non-stall completion cycle; `cnt` restarts at 1.
- `reset` asserted during WAIT at `cnt=4` -> next cycle IDLE with `err=0`. `req=0` in WAIT -> immediate IDLE with no error.
